config_scan_loader: RTL and testbench
=====================================

// Module: config_scan_loader
// PURPOSE
//  Drives the configuration scan chain of the fabric (switch blocks, CLBs): accepts bitstream
//  words over a valid/ready handshake, serialises them onto the chain's scan input with
//  scan_en asserted, and reports completion. Sits between the host/bitstream port and the
//  first shift_reg in the chain; chain_so returns from the last shift_reg in the chain.
// PARAMETERS
//  CHAIN_LEN  32  total configuration bits in the chain (>= 1); 32 = one switch block
//  WORD_W     8   bitstream word width (1..32)
// PORTS
//  clk        in   1        clock; all state changes on rising edge
//  rst_n      in   1        asynchronous active-low reset
//  start      in   1        begin a load; sampled in IDLE only
//  abort      in   1        cancel an active load
//  cfg_data   in   WORD_W   bitstream word
//  cfg_valid  in   1        cfg_data valid
//  cfg_ready  out  1        loader accepts a word this cycle
//  chain_si   out  1        serial data to the chain's scan_in
//  scan_en    out  1        shift enable to every shift_reg in the chain
//  chain_so   in   1        serial data from the chain's scan_out
//  busy       out  1        high in any state other than IDLE
//  done       out  1        one-cycle pulse on successful completion
//  error      out  1        sticky readback mismatch flag
// BEHAVIOUR
//  - Reset: state IDLE; cfg_ready, chain_si, scan_en, busy, done and error all 0; counters 0.
//  - NWORDS = ceil(CHAIN_LEN/WORD_W). Bits are shifted LSB first, word 0 first. The last word
//    contributes only its low CHAIN_LEN-(NWORDS-1)*WORD_W bits; its upper bits are discarded.
//  - FSM: IDLE -start-> FETCH. FETCH: cfg_ready=1; a transfer (cfg_valid & cfg_ready) latches
//    cfg_data and moves to SHIFT on the next cycle. SHIFT: scan_en=1, chain_si=current bit,
//    one bit per clk. After the word's last bit: FETCH if words remain, else READBACK (macro
//    on) or DONE. DONE: done=1 for exactly one cycle, then IDLE.
//  - cfg_ready is 0 outside FETCH. scan_en is 1 only in SHIFT (and READBACK); chain_si is 0
//    whenever scan_en is 0.
//  - Latency with cfg_valid held high: each word costs 1 FETCH cycle + its shift cycles; a
//    32-bit load with WORD_W=8 takes 4*(1+8) cycles from the first FETCH to DONE.
//  - Stall: cfg_valid low in FETCH holds FETCH indefinitely with scan_en=0 (the chain holds).
//  - start while busy is ignored. start and abort together in IDLE: abort wins, stay IDLE.
//  - abort in any non-IDLE state: IDLE next cycle, scan_en=0, no done pulse; chain contents
//    are partial and undefined. abort has priority over a same-cycle cfg transfer.
//  - rst_n low mid-load: immediate IDLE, scan_en drops asynchronously, error cleared.
//  - error is cleared by start being accepted; otherwise held until reset.
// CONFIGURATION
//  CFG_READBACK_EN defined: during SHIFT a CRC-16 (poly 0x1021, init 0xFFFF) accumulates
//   every bit driven on chain_si. READBACK then shifts CHAIN_LEN more cycles with scan_en=1,
//   chain_si=chain_so (recirculation restores the contents), accumulating a second CRC over
//   chain_so. On completion: CRCs equal -> DONE (done pulse); unequal -> error=1, IDLE, no done.
//   abort during READBACK: IDLE, error unchanged.
//  CFG_READBACK_EN undefined: no READBACK state, no CRC logic, error tied 0, chain_so unused.
// TESTING (CHAIN_LEN=32, WORD_W=8, bench models the chain as a 32-bit shift register)
//  - Load words 0xA5,0x3C,0xFF,0x00, cfg_valid held high -> chain_si serial
//    1,0,1,0,0,1,0,1 first; scan_en high 32 cycles total; done pulses 36 cycles after first
//    FETCH; model holds word 0 at the chain_so end.
//  - Drop cfg_valid for 5 cycles before word 2 -> cfg_ready high, scan_en low for those 5
//    cycles; final chain contents identical to the unstalled case.
//  - CHAIN_LEN=20: words 0x11,0x22,0xF3 -> only low nibble 0x3 of word 2 shifted; 20 shift
//    cycles total.
//  - abort asserted on the 3rd SHIFT cycle of word 1 -> IDLE next cycle, scan_en=0, done never
//    pulses; a fresh start then loads correctly.
//  - rst_n pulsed low mid-SHIFT -> scan_en, busy, cfg_ready 0 asynchronously, before next clk.
//  - CFG_READBACK_EN: clean chain -> done after 32 extra cycles, error=0; bench flips one
//    model chain bit before READBACK -> error=1, no done.

Source files
------------

// File: rtl/config_scan_loader.sv
// config_scan_loader: serialises bitstream words LSB-first onto a configuration scan chain.
// Optional feature macro CFG_READBACK_EN: recirculating readback with CRC-16 compare.
module config_scan_loader #(
    parameter int CHAIN_LEN = 32,
    parameter int WORD_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              chain_si,
    output logic              scan_en,
    input  logic              chain_so,
    output logic              busy,
    output logic              done,
    output logic              error
);
    localparam int NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int LAST_BITS = CHAIN_LEN - (NWORDS - 1) * WORD_W;
    localparam int CW        = $clog2(CHAIN_LEN + WORD_W + 1);
    localparam logic [CW-1:0] WORD_END  = CW'(WORD_W - 1);
    localparam logic [CW-1:0] LAST_END  = CW'(LAST_BITS - 1);
    localparam logic [CW-1:0] LAST_WORD = CW'(NWORDS - 1);

`ifdef CFG_READBACK_EN
    typedef enum logic [2:0] {IDLE, FETCH, SHIFT, READBACK, DONE} state_t;
    localparam state_t LOAD_END = READBACK;
    localparam logic [CW-1:0] CHAIN_END = CW'(CHAIN_LEN - 1);
`else
    typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;
    localparam state_t LOAD_END = DONE;
`endif

    state_t            state, state_nxt;
    logic [WORD_W-1:0] sr;
    logic [CW-1:0]     cnt, wcnt;
    logic              take, launch, word_last, bit_last;

    assign launch    = state == IDLE && start && !abort;
    assign take      = state == FETCH && cfg_valid && !abort;
    assign word_last = wcnt == LAST_WORD;
    // the final word may be partial: only its low LAST_BITS bits go out
    assign bit_last  = cnt == (word_last ? LAST_END : WORD_END);

`ifdef CFG_READBACK_EN
    logic [15:0] crc_tx, crc_rx, crc_rx_nxt;
    logic        rb_ok;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
    endfunction

    assign crc_rx_nxt = crc_step(crc_rx, chain_so);
    assign rb_ok      = crc_rx_nxt == crc_tx;

    // CRC over driven bits, CRC over returned bits, and the sticky mismatch flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_tx <= '1;
            crc_rx <= '1;
            error  <= 1'b0;
        end else if (launch) begin
            crc_tx <= '1;
            crc_rx <= '1;
            error  <= 1'b0;
        end else begin
            if (state == SHIFT) crc_tx <= crc_step(crc_tx, sr[0]);
            if (state == READBACK) crc_rx <= crc_rx_nxt;
            if (state == READBACK && cnt == CHAIN_END && !abort && !rb_ok) error <= 1'b1;
        end
    end
`else
    logic unused_so;
    assign unused_so = chain_so;
    assign error     = 1'b0;
`endif

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    end

    // word buffer and bit/word counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr   <= '0;
            cnt  <= '0;
            wcnt <= '0;
        end else if (launch) begin
            cnt  <= '0;
            wcnt <= '0;
        end else if (take) begin
            sr <= cfg_data;
        end else if (state == SHIFT) begin
            sr  <= sr >> 1;
            cnt <= bit_last ? '0 : cnt + 1'b1;
            if (bit_last) wcnt <= wcnt + 1'b1;
        end
`ifdef CFG_READBACK_EN
        else if (state == READBACK) begin
            cnt <= cnt + 1'b1;
        end
`endif
    end

    // next state and Moore outputs; abort overrides every transition
    always_comb begin
        state_nxt = state;
        cfg_ready = 1'b0;
        scan_en   = 1'b0;
        chain_si  = 1'b0;
        done      = 1'b0;
        busy      = state != IDLE;
        case (state)
            IDLE:  state_nxt = start ? FETCH : IDLE;
            FETCH: begin
                cfg_ready = 1'b1;
                state_nxt = cfg_valid ? SHIFT : FETCH;
            end
            SHIFT: begin
                scan_en   = 1'b1;
                chain_si  = sr[0];
                state_nxt = !bit_last ? SHIFT : !word_last ? FETCH : LOAD_END;
            end
`ifdef CFG_READBACK_EN
            READBACK: begin
                scan_en   = 1'b1;
                chain_si  = chain_so;
                state_nxt = cnt != CHAIN_END ? READBACK : rb_ok ? DONE : IDLE;
            end
`endif
            default: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
        endcase
        if (abort) state_nxt = IDLE;
    end
endmodule

// File: tb/tb_config_scan_loader.sv
// tb_config_scan_loader: two loaders (32-bit and 20-bit chains) against a bit-stream reference.
module tb_config_scan_loader;
`ifdef CFG_READBACK_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start [2];
    logic       abort [2];
    logic       valid [2];
    logic [7:0] data  [2];
    logic       ready [2];
    logic       si    [2];
    logic       sen   [2];
    logic       busy  [2];
    logic       done  [2];
    logic       err   [2];
    logic       clr   [2];
    logic       flip  [2];
    logic [7:0] words [4];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    // instance 0: 32-bit chain, instance 1: 20-bit chain; each with a shift-register chain model
    for (genvar g = 0; g < 2; g++) begin : u
        localparam int CL = (g == 0) ? 32 : 20;
        logic [31:0] chain;
        logic [63:0] seen;
        int          nsen;
        int          ndone;
        config_scan_loader #(.CHAIN_LEN(CL), .WORD_W(8)) dut (
            .clk(clk), .rst_n(rst_n), .start(start[g]), .abort(abort[g]),
            .cfg_data(data[g]), .cfg_valid(valid[g]), .cfg_ready(ready[g]),
            .chain_si(si[g]), .scan_en(sen[g]), .chain_so(chain[0]),
            .busy(busy[g]), .done(done[g]), .error(err[g]));
        always @(posedge clk) begin
            if (clr[g]) begin
                chain <= '0;
                seen  <= '0;
                nsen  <= 0;
                ndone <= 0;
            end else begin
                chain <= (sen[g] ? ((chain >> 1) | (32'(si[g]) << (CL - 1))) : chain)
                         ^ (flip[g] ? 32'h20 : 32'h0);
                if (sen[g]) begin
                    if (nsen < 64) seen[nsen] <= si[g];
                    nsen <= nsen + 1;
                end
                if (done[g]) ndone <= ndone + 1;
            end
        end
    end

    function automatic logic [63:0] seen_of(input int g);
        return g != 0 ? u[1].seen : u[0].seen;
    endfunction
    function automatic logic [31:0] chain_of(input int g);
        return g != 0 ? u[1].chain : u[0].chain;
    endfunction
    function automatic int nsen_of(input int g);
        return g != 0 ? u[1].nsen : u[0].nsen;
    endfunction
    function automatic int ndone_of(input int g);
        return g != 0 ? u[1].ndone : u[0].ndone;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one load on instance g; start is toggled randomly while busy and must be ignored
    task automatic run_load(input int g, input int cl, input int nw, input int stall_k,
                            input int stall_n, input int abort_at, input int flip_at);
        int          k, s, ns, cyc;
        logic [63:0] exp_bits, mask;
        k = 0; s = stall_n; ns = 0; cyc = 0;
        clr[g] = 1'b1;
        @(negedge clk);
        clr[g] = 1'b0;
        start[g] = 1'b1;
        @(negedge clk);
        while (!done[g] && busy[g] && cyc < 400) begin
            start[g] = 1'($urandom);
            if (abort_at >= 0 && sen[g] && ns == abort_at) abort[g] = 1'b1;
            if (flip_at >= 0 && sen[g] && ns == flip_at) flip[g] = 1'b1;
            if (sen[g]) ns++;
            if (k == stall_k && s > 0 && (s < stall_n || ready[g])) begin
                valid[g] = 1'b0;
                check("stall_ready", 64'(ready[g]), 64'd1);
                check("stall_scan_en", 64'(sen[g]), 64'd0);
                s--;
            end else begin
                valid[g] = 1'b1;
                data[g]  = words[k < nw ? k : 0];
                if (ready[g]) k++;
            end
            @(negedge clk);
            abort[g] = 1'b0;
            flip[g]  = 1'b0;
            cyc++;
        end
        start[g] = 1'b0;
        valid[g] = 1'b0;
        check("no_timeout", 64'(cyc < 400), 64'd1);
        mask = (64'd1 << cl) - 64'd1;
        exp_bits = '0;
        for (int i = 0; i < cl; i++) exp_bits[i] = words[i / 8][i % 8];
        if (abort_at >= 0) begin
            check("abort_busy", 64'(busy[g]), 64'd0);
            check("abort_scan_en", 64'(sen[g]), 64'd0);
            check("abort_ready", 64'(ready[g]), 64'd0);
            repeat (3) @(negedge clk);
            check("abort_no_done", 64'(ndone_of(g)), 64'd0);
        end else if (flip_at >= 0) begin
            @(negedge clk);
            check("rb_error", 64'(err[g]), 64'd1);
            check("rb_no_done", 64'(ndone_of(g)), 64'd0);
        end else begin
            @(negedge clk);
            check("load_cycles", 64'(cyc), 64'(nw + cl * (1 + RB) + stall_n));
            check("scan_en_cycles", 64'(nsen_of(g)), 64'(cl * (1 + RB)));
            check("si_stream", seen_of(g) & mask, exp_bits);
            if (RB != 0) check("readback_stream", (seen_of(g) >> cl) & mask, exp_bits);
            check("chain_contents", 64'(chain_of(g)), exp_bits);
            check("done_pulses", 64'(ndone_of(g)), 64'd1);
            check("error_clear", 64'(err[g]), 64'd0);
            check("idle_after", 64'(busy[g]), 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        for (int g = 0; g < 2; g++) begin
            start[g] = 1'b0; abort[g] = 1'b0; valid[g] = 1'b0;
            data[g] = '0; clr[g] = 1'b0; flip[g] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check("rst_ready", 64'(ready[g]), 64'd0);
            check("rst_si", 64'(si[g]), 64'd0);
            check("rst_scan_en", 64'(sen[g]), 64'd0);
            check("rst_busy", 64'(busy[g]), 64'd0);
            check("rst_done", 64'(done[g]), 64'd0);
            check("rst_error", 64'(err[g]), 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        words = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
        run_load(0, 32, 4, -1, 0, -1, -1);
        check("first_bits", 64'(seen_of(0) & 64'hFF), 64'hA5);
        check("word0_at_so", 64'(chain_of(0) & 32'hFF), 64'hA5);

        run_load(0, 32, 4, 2, 5, -1, -1);
        check("stall_chain", 64'(chain_of(0)), 64'h00FF3CA5);

        words = '{8'h11, 8'h22, 8'hF3, 8'h00};
        run_load(1, 20, 3, -1, 0, -1, -1);
        check("cl20_chain", 64'(chain_of(1)), 64'h32211);

        for (int i = 0; i < 4; i++) words[i] = 8'($urandom);
        run_load(0, 32, 4, -1, 0, 10, -1);
        for (int i = 0; i < 4; i++) words[i] = 8'($urandom);
        run_load(0, 32, 4, -1, 0, -1, -1);

        start[0] = 1'b1;
        abort[0] = 1'b1;
        @(negedge clk);
        check("start_abort_idle", 64'(busy[0]), 64'd0);
        check("start_abort_ready", 64'(ready[0]), 64'd0);
        start[0] = 1'b0;
        abort[0] = 1'b0;

        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < 4; i++) words[i] = 8'($urandom);
            if (n % 2 == 0) run_load(0, 32, 4, int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), -1, -1);
            else run_load(1, 20, 3, int'($urandom_range(0, 2)), int'($urandom_range(0, 4)), -1, -1);
        end

        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        valid[0] = 1'b1;
        data[0]  = 8'($urandom);
        repeat (3) @(negedge clk);
        check("pre_rst_scan_en", 64'(sen[0]), 64'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_scan_en", 64'(sen[0]), 64'd0);
        check("async_rst_busy", 64'(busy[0]), 64'd0);
        check("async_rst_ready", 64'(ready[0]), 64'd0);
        check("async_rst_si", 64'(si[0]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        valid[0] = 1'b0;
        @(negedge clk);

`ifdef CFG_READBACK_EN
        for (int i = 0; i < 4; i++) words[i] = 8'($urandom);
        run_load(0, 32, 4, -1, 0, -1, 31);
        for (int i = 0; i < 4; i++) words[i] = 8'($urandom);
        run_load(0, 32, 4, -1, 0, -1, -1);
`endif
        for (int i = 0; i < 4; i++) words[i] = 8'($urandom);
        run_load(1, 20, 3, -1, 0, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
